// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and baud timing constants shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_t;
  localparam int CLOCK_FREQ        = 50_000_000;
  localparam int BAUD_RATE         = 9600;
  localparam int CLKS_PER_BIT      = CLOCK_FREQ / BAUD_RATE;
  localparam int CLKS_PER_HALF_BIT = CLKS_PER_BIT / 2;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16-bit bit-period counter; bit_end marks the last clock of each serial bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  logic [15:0] clk_count;
  assign bit_end = clk_count == LAST;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) clk_count <= '0;
    else clk_count <= clear || bit_end ? '0 : clk_count + 16'd1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serialiser with a one-byte holding register behind a valid/ready handshake
module uart_transmitter import uart_pkg::*; #(
  parameter int CLOCK_FREQ   = uart_pkg::CLOCK_FREQ,
  parameter int BAUD_RATE    = uart_pkg::BAUD_RATE,
  parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);
  uart_state_t state;
  logic [7:0] hold, shift;
  logic [2:0] bit_index;
  logic hold_full, bit_end;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .clear(state == IDLE),
    .bit_end(bit_end)
  );
  assign tx_ready = !hold_full;
  assign tx_busy  = state != IDLE || hold_full;
  assign tx_done  = state == STOP_BIT && bit_end;
  // txd is driven one clock ahead of each bit so the line is a clean register output
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      hold      <= '0;
      shift     <= '0;
      hold_full <= 1'b0;
      bit_index <= '0;
    end else begin
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: if (hold_full) begin
          shift     <= hold;
          hold_full <= 1'b0;
          txd       <= 1'b0;
          state     <= START_BIT;
        end
        START_BIT: if (bit_end) begin
          txd       <= shift[0];
          bit_index <= '0;
          state     <= DATA_BITS;
        end
        DATA_BITS: if (bit_end) begin
          txd       <= bit_index == 3'd7 ? 1'b1 : shift[bit_index + 3'd1];
          bit_index <= bit_index + 3'd1;
          state     <= bit_index == 3'd7 ? STOP_BIT : DATA_BITS;
        end
        STOP_BIT: if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized and directed checks of uart_transmitter against a frame-timeline model
module tb_uart_transmitter;
  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0, reset_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, txd, tx_busy, tx_done;
  int total = 0, bad = 0;
  uart_transmitter #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(5_000_000)) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd(txd),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // Model: a frame occupies FRAME cycles from its start; a held byte starts the cycle after the line is free
  int cyc = 0, fs = 0;
  bit hf = 0, fa = 0, acc, mbusy;
  logic [7:0] hb = 8'h00, fb = 8'h00;
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      hf = 0;
      fa = 0;
    end else begin
      acc = tx_valid && !hf;
      mbusy = fa && (cyc - fs) < FRAME;
      if (!mbusy && hf) begin
        fs = cyc + 1;
        fa = 1;
        fb = hb;
        hf = 0;
      end
      if (acc) begin
        hf = 1;
        hb = tx_data;
      end
      cyc++;
    end
  end
  int k, dk = 0;
  bit inf, dec_on = 0;
  logic e;
  logic [7:0] dbyte = 8'h00;
  logic [7:0] rxq[$];
  time falls[$], dones[$];
  initial forever begin
    @(negedge clk);
    if (!reset_n) dec_on = 0;
    else begin
      k = cyc - fs;
      inf = fa && k < FRAME;
      e = !inf || k >= 9 * CPB ? 1'b1 : k < CPB ? 1'b0 : fb[k / CPB - 1];
      chk("txd", int'(txd), int'(e));
      chk("tx_ready", int'(tx_ready), int'(!hf));
      chk("tx_busy", int'(tx_busy), int'(inf || hf));
      chk("tx_done", int'(tx_done), int'(inf && k == FRAME - 1));
      if (tx_done) dones.push_back($time);
      if (!dec_on) begin
        if (!txd) begin
          dec_on = 1;
          dk = 0;
          falls.push_back($time);
        end
      end else begin
        dk++;
        if (dk % CPB == CPB / 2 && dk / CPB >= 1 && dk / CPB <= 8) dbyte[dk / CPB - 1] = txd;
        if (dk == 9 * CPB + CPB / 2) begin
          rxq.push_back(dbyte);
          dec_on = 0;
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, input bit keep, output time h);
    int n = 0;
    @(posedge clk);
    #2 tx_valid = 1'b1;
    tx_data = b;
    @(negedge clk);
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_timeout", int'(n < 500), 1);
    h = $time;
    @(posedge clk);
    #2;
    if (!keep) begin
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 3000);
    chk("idle_timeout", int'(n < 3000), 1);
    repeat (CPB) @(negedge clk);
  endtask
  initial begin
    time h, h2;
    int q0, d0, f0;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    logic [7:0] four[4];
    four = '{8'h00, 8'hFF, 8'h80, 8'h01};
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    repeat (300) @(negedge clk);
    chk("idle_no_activity", falls.size() + dones.size(), 0);
    send(8'h55, 0, h);
    wait_idle();
    chk("55_latency", int'((falls[0] - h) / 10), 2);
    chk("55_done_offset", int'((dones[0] - falls[0]) / 10), 99);
    chk("55_byte", int'(rxq[0]), 8'h55);
    q0 = rxq.size();
    d0 = dones.size();
    send(8'hA5, 0, h);
    send(8'h3C, 0, h2);
    @(negedge clk);
    chk("b2b_ready_low", int'(tx_ready), 0);
    chk("b2b_busy", int'(tx_busy), 1);
    wait_idle();
    chk("b2b_done_count", dones.size() - d0, 2);
    chk("b2b_spacing", int'((dones[d0 + 1] - dones[d0]) / 10), 101);
    chk("b2b_byte0", int'(rxq[q0]), 8'hA5);
    chk("b2b_byte1", int'(rxq[q0 + 1]), 8'h3C);
    q0 = rxq.size();
    d0 = dones.size();
    foreach (four[i]) send(four[i], i != 3, h);
    wait_idle();
    chk("held_done_count", dones.size() - d0, 4);
    chk("held_byte_count", rxq.size() - q0, 4);
    for (int i = 1; i < 4; i++) chk("held_spacing", int'((dones[d0 + i] - dones[d0 + i - 1]) / 10), 101);
    foreach (four[i]) chk("held_byte", int'(rxq[q0 + i]), int'(four[i]));
    q0 = rxq.size();
    repeat (25) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 120)) begin
        @(posedge clk);
        #2 tx_data = 8'($urandom);
      end
      send(b, 0, h);
      exp_q.push_back(b);
    end
    wait_idle();
    chk("rand_count", rxq.size() - q0, exp_q.size());
    foreach (exp_q[i]) chk("rand_byte", int'(rxq[q0 + i]), int'(exp_q[i]));
    f0 = falls.size();
    q0 = rxq.size();
    send(8'hF0, 0, h);
    send(8'h12, 0, h2);
    repeat (44) @(posedge clk);
    #1 chk("pre_reset_txd", int'(txd), 0);
    reset_n = 1'b0;
    #1 chk("reset_txd", int'(txd), 1);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(tx_busy), 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("post_reset_falls", falls.size() - f0, 1);
    chk("post_reset_bytes", rxq.size() - q0, 0);
    chk("post_reset_txd", int'(txd), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
8N1 UART transmitter for the DE-board FPGA design. It accepts one byte per valid/ready handshake, buffers one further byte in a single-entry holding register, and serialises each byte LSB-first onto a GPIO pin at BAUD_RATE. This is the return path to the host: it echoes or reports the sensor values the UART receiver shows on HEX/LEDR. Timing is derived directly from CLOCK_50 with no external baud generator.

Parameters:
CLOCK_FREQ, 50000000, input clock frequency in Hz
BAUD_RATE, 9600, line bit rate
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (5208), clocks per serial bit; must fit in 16 bits

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to send; sampled when tx_valid && tx_ready
tx_valid  input  1  producer has a byte
tx_ready  output  1  holding register empty; may depend only on state, never combinationally on tx_valid
txd  output  1  serial line, idle high; registered
tx_busy  output  1  shift FSM not IDLE, or holding register full
tx_done  output  1  one-cycle pulse in the last clock of every stop bit

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is CLOCK_50.
- Reset values: txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, hold register empty, counters 0.
- Reset asserted mid-frame aborts immediately: txd returns to 1 asynchronously and any held byte is discarded.
- States:
  - IDLE, START_BIT, DATA_BITS, STOP_BIT.
- Holding register:
  - Loaded on tx_valid && tx_ready; tx_ready deasserts the next cycle.
  - In the same cycle tx_ready goes low, tx_busy rises.
- IDLE:
  - If the hold register is full, move it into the shift register, mark the hold register empty (tx_ready=1 next cycle), enter START_BIT, clear clk_count.
  - Latency: handshake cycle N → hold register full at N+1 → txd=0 from N+2.
- START_BIT: txd=0 for exactly CLKS_PER_BIT clocks, then enter DATA_BITS with bit_index=0.
- DATA_BITS:
  - txd=shift[bit_index] for CLKS_PER_BIT clocks per bit, LSB first.
  - After bit_index==7 completes, enter STOP_BIT. bit_index wraps to 0.
- STOP_BIT:
  - txd=1 for CLKS_PER_BIT clocks. tx_done pulses on the final count.
  - Next state is IDLE. If the hold register is full, the next start bit begins 1 clock later, with no extra idle bit.
- Frame length: exactly 10*CLKS_PER_BIT clocks, ±0 cycles.
- clk_count is 16 bits and counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary.
- Simultaneous events: a handshake in the same cycle that IDLE consumes the hold register cannot occur, because tx_ready is 0 while the hold register is full. A handshake during any frame state is accepted if the hold register is empty.
- tx_data changing while tx_valid=0 or tx_ready=0 has no effect.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE=0, START_BIT=1, DATA_BITS=2, STOP_BIT=3, shared with the receiver.
  - Constants CLOCK_FREQ, BAUD_RATE, CLKS_PER_BIT, CLKS_PER_HALF_BIT.
- One natural sub-module, uart_baud_tick:
  - A 16-bit counter with clear input and a bit_end pulse output.
  - Reusable by the receiver.
- The top-level wrapper connects txd to GPIO_1[1], and tx_data/tx_valid to the receiver's byte/data_valid.

Test Plan:
- Reset then idle 20000 clocks → txd constantly 1, tx_ready=1, tx_busy=0, no tx_done.
- Send 0x55 → txd: low 5208 clks, then 1,0,1,0,1,0,1,0, each 5208 clks, then high 5208. tx_done once at clock 52079 after start edge.
- Send 0xA5 then 0x3C back-to-back → second handshake accepted during first frame; tx_ready low until first frame's IDLE transfer. Second start bit begins 1 clock after first stop ends; decoded bytes are 0xA5, 0x3C.
- Hold tx_valid=1 with 4 bytes (0x00, 0xFF, 0x80, 0x01) → 4 contiguous frames, 4 tx_done pulses spaced 52081 clks; no byte dropped or duplicated.
- Assert reset_n=0 during bit 3 of 0xF0 with a second byte held → txd=1 within the same cycle, tx_ready=1; after release, no frame is emitted.
- Loopback into uart_receiver (txd→rxd): send 0, 99, 200 → receiver HEX shows 000, 099, 200; send 201 → receiver display unchanged.
